gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
Parametrised GPIO controller with a register interface; next generation of the single-port GPIO register block. Adds configurable pin count, real synchronised pin inputs, atomic SET/CLR/TGL writes, per-pin rise/fall edge interrupts with write-1-to-clear status, and a registered read-valid strobe. Sits on the CPU peripheral bus and drives the pad ring.

Parameters:
WIDTH, 32, number of GPIO pins (1..32); bus data stays 32 bits, unused upper bits read 0 and ignore writes.
SYNC_STAGES, 2, input synchroniser depth (2..3).
DEB_CYCLES, 16, debounce stable-count; used only with GPIO_DEBOUNCE_EN.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  bus access strobe, one cycle per access
wr  in  1  1 = write, 0 = read (qualified by en)
addr_offset  in  8  byte offset of register
data_in  in  32  write data
data_out  out  32  read data, registered
rd_valid  out  1  one-cycle pulse: data_out valid
gpio_in  in  WIDTH  asynchronous pad inputs
gpio_out  out  WIDTH  pad output values
gpio_oe  out  WIDTH  pad output enables (1 = drive)
irq  out  1  level interrupt, OR of IRQ_STATUS

Behaviour:
- Register map:
  - 0x00 DATA (RW)
  - 0x04 DIR (RW, 1 = output)
  - 0x08 PIN (RO, synchronised pin value)
  - 0x0C SET (WO, DATA |= wdata)
  - 0x10 CLR (WO, DATA &= ~wdata)
  - 0x14 TGL (WO, DATA ^= wdata)
  - 0x18 IE_RISE (RW)
  - 0x1C IE_FALL (RW)
  - 0x20 IRQ_STATUS (RW1C)
- Unmapped offsets: writes ignored; reads return 0 with rd_valid asserted. SET/CLR/TGL read 0.
- Reset: DATA, DIR, IE_RISE, IE_FALL, IRQ_STATUS, data_out, synchroniser flops all 0; rd_valid=0, irq=0, gpio_oe=0, gpio_out=0.
- gpio_out = DATA & DIR; gpio_oe = DIR; both are registers, so a write is visible on the pins the cycle after the write cycle.
- Pin path: gpio_in passes through a SYNC_STAGES flop chain giving sync; one further flop holds prev.
  - PIN returns (DATA & DIR) | (sync & ~DIR).
- Edge detection on sync vs prev:
  - rise = sync & ~prev; fall = ~sync & prev.
  - Edges are detected regardless of DIR.
  - IRQ_STATUS[i] sets when (rise[i] & IE_RISE[i]) | (fall[i] & IE_FALL[i]).
- Read: en & ~wr at cycle N gives data_out and rd_valid=1 at N+1. data_out holds its value until the next read. rd_valid is 0 otherwise.
- Write takes effect at the clock edge ending the en & wr cycle.
- Simultaneous events:
  - W1C write and a new edge set on the same bit in the same cycle: the set wins, so the bit stays 1.
  - Write to DATA/SET/CLR/TGL is a single-cycle operation; no conflict is possible.
  - Enabling IE after an edge has already occurred does not retroactively set status.
- irq = |IRQ_STATUS, registered, so it asserts one cycle after the status bit sets.
- rst mid-operation: all state clears the next edge. A read issued in the reset cycle produces no rd_valid.
- Bits >= WIDTH: write-ignored, read 0, never set status.

Optional Feature:
GPIO_DEBOUNCE_EN.
- Defined: each pin has a counter after the synchroniser. The debounced value updates only after sync differs from it for DEB_CYCLES consecutive cycles, and the counter resets on any bounce. PIN and edge detection use the debounced value. Edge latency grows by DEB_CYCLES.
- Undefined: no counters; PIN and edge detection use sync directly.

Decomposition:
- Package gpio_pkg holds the register offset constants (GPIO_OFF_DATA ... GPIO_OFF_IRQ_STATUS) and the bus data width constant (32).
- One natural sub-module, gpio_pin_sync: one pin's synchroniser, optional debounce, prev flop, and rise/fall outputs. It is instantiated WIDTH times via generate.
- Register file, read mux, and IRQ logic live in gpio_ctrl.

Test Plan:
1. Reset then read all offsets 0x00..0x20 -> every data_out = 0, rd_valid pulses one cycle after each en, gpio_oe = 0.
2. Write DIR=0x0000_00FF, DATA=0x1234_5678 -> gpio_out=0x0000_0078 the next cycle. Then SET 0x100, CLR 0x08, TGL 0x03 -> DATA reads 0x1234_5773, gpio_out=0x73.
3. DIR=0, gpio_in=0xA5 held -> PIN read reflects 0xA5 no earlier than the read issued SYNC_STAGES cycles after the change. With DIR=0x0F and DATA=0x0 -> PIN=0xA0.
4. IE_RISE=0x1, IE_FALL=0x2; drive gpio_in[0] 0->1 and gpio_in[1] 1->0 -> IRQ_STATUS=0x3, irq=1. Write IRQ_STATUS=0x1 -> status=0x2, irq stays 1. Write 0x2 -> irq=0.
5. Schedule a W1C of bit 0 in the same cycle a new rising edge on pin 0 is detected -> IRQ_STATUS[0] remains 1.
6. WIDTH=8 build: write DATA=0xFFFF_FFFF -> reads 0x0000_00FF. Unmapped offset 0x40 read -> 0 with rd_valid. With GPIO_DEBOUNCE_EN, a 5-cycle glitch on gpio_in[0] with DEB_CYCLES=16 -> no status set.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the GPIO controller register block.
// Holds the bus data width and the byte offsets of every mapped register.
package gpio_pkg;

  localparam int GPIO_BUS_W = 32;

  localparam logic [7:0] GPIO_OFF_DATA       = 8'h00;
  localparam logic [7:0] GPIO_OFF_DIR        = 8'h04;
  localparam logic [7:0] GPIO_OFF_PIN        = 8'h08;
  localparam logic [7:0] GPIO_OFF_SET        = 8'h0C;
  localparam logic [7:0] GPIO_OFF_CLR        = 8'h10;
  localparam logic [7:0] GPIO_OFF_TGL        = 8'h14;
  localparam logic [7:0] GPIO_OFF_IE_RISE    = 8'h18;
  localparam logic [7:0] GPIO_OFF_IE_FALL    = 8'h1C;
  localparam logic [7:0] GPIO_OFF_IRQ_STATUS = 8'h20;

endpackage

// File: rtl/gpio_pin_sync.sv
// gpio_pin_sync: one pad input's synchroniser chain, optional debounce
// filter (built when GPIO_DEBOUNCE_EN is defined), the previous-value flop
// and the rise/fall pulses derived from them.
module gpio_pin_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_async,
  output logic pin_val,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   prev_q;

  // Shift the asynchronous pad value through the metastability chain.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pin_async};
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             deb_q;

  // Accept a new level only after it has differed for DEB_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (sync != deb_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        deb_q <= sync;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign pin_val = deb_q;
`else
  // Debounce length is meaningless without the filter.
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign pin_val    = sync;
`endif

  // Remember last cycle's filtered level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= pin_val;
  end

  assign rise = pin_val & ~prev_q;
  assign fall = ~pin_val & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: parametrised GPIO register block with atomic SET/CLR/TGL,
// synchronised pin inputs, rise/fall edge interrupts (W1C status) and a
// registered read port with a one-cycle rd_valid strobe.
// Optional build macro: GPIO_DEBOUNCE_EN adds a per-pin debounce filter.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr,
  input  logic [7:0]            addr_offset,
  input  logic [GPIO_BUS_W-1:0] data_in,
  output logic [GPIO_BUS_W-1:0] data_out,
  output logic                  rd_valid,
  input  logic [WIDTH-1:0]      gpio_in,
  output logic [WIDTH-1:0]      gpio_out,
  output logic [WIDTH-1:0]      gpio_oe,
  output logic                  irq
);

  logic [WIDTH-1:0] data_q, dir_q, ie_rise_q, ie_fall_q, status_q;
  logic [WIDTH-1:0] data_nxt, dir_nxt, ie_rise_nxt, ie_fall_nxt, w1c;
  logic [WIDTH-1:0] pin_val, rise, fall, wdata, pin_rd;
  logic [GPIO_BUS_W-1:0] rd_word;
  logic wr_en, rd_en;

  assign wr_en  = en & wr;
  assign rd_en  = en & ~wr;
  assign wdata  = data_in[WIDTH-1:0];
  assign pin_rd = (data_q & dir_q) | (pin_val & ~dir_q);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_pin_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_pin (
      .clk      (clk),
      .rst      (rst),
      .pin_async(gpio_in[i]),
      .pin_val  (pin_val[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

  function automatic logic [GPIO_BUS_W-1:0] zext(input logic [WIDTH-1:0] v);
    zext           = '0;
    zext[WIDTH-1:0] = v;
  endfunction

  // Decode a bus write into next-state values for the writable registers.
  // NOTE: every output gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    data_nxt    = data_q;
    dir_nxt     = dir_q;
    ie_rise_nxt = ie_rise_q;
    ie_fall_nxt = ie_fall_q;
    w1c         = '0;
    if (wr_en) begin
      case (addr_offset)
        GPIO_OFF_DATA:       data_nxt    = wdata;
        GPIO_OFF_DIR:        dir_nxt     = wdata;
        GPIO_OFF_SET:        data_nxt    = data_q | wdata;
        GPIO_OFF_CLR:        data_nxt    = data_q & ~wdata;
        GPIO_OFF_TGL:        data_nxt    = data_q ^ wdata;
        GPIO_OFF_IE_RISE:    ie_rise_nxt = wdata;
        GPIO_OFF_IE_FALL:    ie_fall_nxt = wdata;
        GPIO_OFF_IRQ_STATUS: w1c         = wdata;
        default: ;
      endcase
    end
  end

  // Select the register returned by a read; unmapped and write-only offsets read 0.
  always_comb begin
    rd_word = '0;
    case (addr_offset)
      GPIO_OFF_DATA:       rd_word = zext(data_q);
      GPIO_OFF_DIR:        rd_word = zext(dir_q);
      GPIO_OFF_PIN:        rd_word = zext(pin_rd);
      GPIO_OFF_IE_RISE:    rd_word = zext(ie_rise_q);
      GPIO_OFF_IE_FALL:    rd_word = zext(ie_fall_q);
      GPIO_OFF_IRQ_STATUS: rd_word = zext(status_q);
      default: ;
    endcase
  end

  // Register file, pad drivers and interrupt state; a new edge beats a W1C clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      dir_q     <= '0;
      ie_rise_q <= '0;
      ie_fall_q <= '0;
      status_q  <= '0;
      gpio_out  <= '0;
      gpio_oe   <= '0;
      irq       <= 1'b0;
    end else begin
      data_q    <= data_nxt;
      dir_q     <= dir_nxt;
      ie_rise_q <= ie_rise_nxt;
      ie_fall_q <= ie_fall_nxt;
      status_q  <= (status_q & ~w1c) | (rise & ie_rise_q) | (fall & ie_fall_q);
      gpio_out  <= data_nxt & dir_nxt;
      gpio_oe   <= dir_nxt;
      irq       <= |status_q;
    end
  end

  // Registered read port: data_out holds until the next read, rd_valid pulses once.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) data_out <= rd_word;
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed plus randomized checks of gpio_ctrl against a
// behavioural register/pin model. A second 8-pin instance shares the bus.
module tb_gpio_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int DEB_CYCLES  = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SYNC_STAGES + DEB_CYCLES;
`else
  localparam int LAT = SYNC_STAGES;
`endif
  localparam int SETTLE = LAT + 4;

  logic        clk = 1'b0;
  logic        rst, en, wr;
  logic [7:0]  addr_offset;
  logic [31:0] data_in, data_out, data_out8;
  logic        rd_valid, rd_valid8, irq, irq8;
  logic [31:0] gpio_in, gpio_out, gpio_oe;
  logic [7:0]  gpio_out8, gpio_oe8;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  logic [31:0] m_data, m_dir, m_ier, m_ief, m_stat, m_pin;

  always #5 clk = ~clk;

  gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr_offset(addr_offset),
    .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq));

  gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr_offset(addr_offset),
    .data_in(data_in), .data_out(data_out8), .rd_valid(rd_valid8),
    .gpio_in(gpio_in[7:0]), .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [7:0] off);
    case (off)
      8'h00:   return m_data;
      8'h04:   return m_dir;
      8'h08:   return (m_data & m_dir) | (m_pin & ~m_dir);
      8'h18:   return m_ier;
      8'h1C:   return m_ief;
      8'h20:   return m_stat;
      default: return 32'h0;
    endcase
  endfunction

  task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr_offset = off; data_in = d;
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] off);
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr_offset = off;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Write through the bus and apply the register-map rules to the model.
  task automatic do_write(input logic [7:0] off, input logic [31:0] d);
    case (off)
      8'h00: m_data = d;
      8'h04: m_dir  = d;
      8'h0C: m_data = m_data | d;
      8'h10: m_data = m_data & ~d;
      8'h14: m_data = m_data ^ d;
      8'h18: m_ier  = d;
      8'h1C: m_ief  = d;
      8'h20: m_stat = m_stat & ~d;
      default: ;
    endcase
    bus_write(off, d);
    check("gpio_out", gpio_out, m_data & m_dir);
    check("gpio_oe", gpio_oe, m_dir);
    @(negedge clk);
    check("irq_after_wr", {31'd0, irq}, {31'd0, m_stat != 0});
  endtask

  task automatic do_read(input string tag, input logic [7:0] off);
    logic [31:0] exp;
    exp = exp_read(off);
    bus_read(off);
    check(tag, data_out, exp);
    check({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
  endtask

  // Change the pads, let the change settle, and record any enabled edges.
  task automatic do_pin(input logic [31:0] v);
    m_stat = m_stat | (v & ~m_pin & m_ier) | (~v & m_pin & m_ief);
    m_pin  = v;
    @(negedge clk);
    gpio_in = v;
    repeat (SETTLE) @(negedge clk);
    check("irq_after_pin", {31'd0, irq}, {31'd0, m_stat != 0});
  endtask

  logic [7:0] wr_offs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10,
                               8'h14, 8'h18, 8'h1C, 8'h20, 8'h24};

  initial begin
    m_data = '0; m_dir = '0; m_ier = '0; m_ief = '0; m_stat = '0; m_pin = '0;
    gpio_in = '0; data_in = '0; addr_offset = '0;
    // read issued while reset is held must not produce rd_valid
    rst = 1'b1; en = 1'b1; wr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_gpio_oe", gpio_oe, 32'd0);
    check("rst_gpio_out", gpio_out, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_gpio_oe8", {24'd0, gpio_oe8}, 32'd0);
    check("rst_irq8", {31'd0, irq8}, 32'd0);
    rst = 1'b0; en = 1'b0;

    // 1: every offset reads zero after reset, rd_valid is a single pulse
    for (int a = 0; a <= 8'h20; a += 4) begin
      bus_read(8'(a));
      check($sformatf("rst_rd_%02h", a), data_out, 32'd0);
      check("rst_rd_vld", {31'd0, rd_valid}, 32'd1);
    end
    @(negedge clk);
    check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);

    // 2: DATA/DIR then atomic SET/CLR/TGL
    do_write(8'h04, 32'h0000_00FF);
    do_write(8'h00, 32'h1234_5678);
    check("out_78", gpio_out, 32'h0000_0078);
    do_write(8'h0C, 32'h0000_0100);
    do_write(8'h10, 32'h0000_0008);
    do_write(8'h14, 32'h0000_0003);
    bus_read(8'h00);
    check("data_5773", data_out, 32'h1234_5773);
    check("out_73", gpio_out, 32'h0000_0073);
    do_read("rd_set", 8'h0C);
    do_read("rd_clr", 8'h10);
    do_read("rd_tgl", 8'h14);

    // 3: synchronised PIN value
    do_write(8'h04, 32'h0);
    @(negedge clk);
    gpio_in = 32'h0000_00A5;
    en = 1'b1; wr = 1'b0; addr_offset = 8'h08;
    @(negedge clk);
    en = 1'b0;
    check("pin_too_early", data_out, 32'h0);
    repeat (SETTLE) @(negedge clk);
    m_pin = 32'h0000_00A5;
    bus_read(8'h08);
    check("pin_a5", data_out, 32'h0000_00A5);
    do_write(8'h04, 32'h0000_000F);
    do_write(8'h00, 32'h0);
    bus_read(8'h08);
    check("pin_a0", data_out, 32'h0000_00A0);

    // 4: edge interrupts and W1C
    do_pin(32'h0000_0002);
    do_write(8'h18, 32'h1);
    do_write(8'h1C, 32'h2);
    do_pin(32'h0000_0001);
    bus_read(8'h20);
    check("stat_3", data_out, 32'h3);
    check("irq_set", {31'd0, irq}, 32'd1);
    do_write(8'h20, 32'h1);
    do_read("stat_2", 8'h20);
    check("irq_still", {31'd0, irq}, 32'd1);
    do_write(8'h20, 32'h2);
    check("irq_clr", {31'd0, irq}, 32'd0);

    // 5: W1C collides with a fresh rising edge on the same bit
    do_pin(32'h0);
    do_pin(32'h1);
    do_pin(32'h0);
    @(negedge clk);
    gpio_in = 32'h1;
    m_pin   = 32'h1;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr_offset = 8'h20; data_in = 32'h1;
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
    bus_read(8'h20);
    check("set_beats_w1c", data_out, 32'h1);
    do_write(8'h20, 32'hFFFF_FFFF);

    // random register traffic and pad activity against the model
    for (int it = 0; it < 160; it++) begin
      int unsigned op;
      logic [7:0]  off;
      op = $urandom_range(0, 9);
      if (op < 4) begin
        off = wr_offs[$urandom_range(0, 9)];
        do_write(off, $urandom);
      end else if (op < 7) begin
        if ($urandom_range(0, 3) == 0) off = 8'($urandom_range(0, 255));
        else                           off = 8'($urandom_range(0, 16) * 4);
        do_read("rnd_rd", off);
      end else begin
        do_pin($urandom);
      end
    end

    // 6: narrow instance masks upper bits, unmapped offset reads zero
    do_write(8'h04, 32'hFFFF_FFFF);
    do_write(8'h00, 32'hFFFF_FFFF);
    bus_read(8'h00);
    check("w32_data", data_out, 32'hFFFF_FFFF);
    check("w8_data", data_out8, 32'h0000_00FF);
    check("w8_out", {24'd0, gpio_out8}, 32'h0000_00FF);
    do_read("unmapped_40", 8'h40);
    check("w8_unmapped", data_out8, 32'h0);
    check("w8_unmapped_vld", {31'd0, rd_valid8}, 32'd1);

`ifdef GPIO_DEBOUNCE_EN
    // short glitch must be filtered out
    do_write(8'h04, 32'h0);
    do_pin(32'h0);
    do_write(8'h18, 32'h1);
    do_write(8'h20, 32'hFFFF_FFFF);
    @(negedge clk);
    gpio_in = 32'h1;
    repeat (5) @(negedge clk);
    gpio_in = 32'h0;
    repeat (SETTLE) @(negedge clk);
    do_read("deb_glitch", 8'h20);
`endif

    // reset mid-operation with a read in the same cycle
    @(negedge clk);
    rst = 1'b1; en = 1'b1; wr = 1'b0; addr_offset = 8'h00;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    m_data = '0; m_dir = '0; m_ier = '0; m_ief = '0; m_stat = '0;
    check("mid_rst_vld", {31'd0, rd_valid}, 32'd0);
    check("mid_rst_oe", gpio_oe, 32'd0);
    check("mid_rst_out", gpio_out, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    repeat (SETTLE) @(negedge clk);
    do_read("post_rst_data", 8'h00);
    do_read("post_rst_pin", 8'h08);
    do_read("post_rst_stat", 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
